// File: rtl/l_stages_pkg.sv
// -----------------------------------------------------------------------------
// l_stages_pkg
//
// Shared definitions for the L-stage launch controller: the controller FSM
// state encoding and the default sizing constants used by l_stages_ctrl.
//
// Contents:
//   DEF_NUM_UNITS  default number of butterfly units driven
//   DEF_STAGE_W    default width of a stage index
//   DEF_CNT_W      default width of the stage-count input
//   state_t        controller state (IDLE must encode as zero)
// -----------------------------------------------------------------------------
package l_stages_pkg;

  localparam int DEF_NUM_UNITS = 4;
  localparam int DEF_STAGE_W   = 32;
  localparam int DEF_CNT_W     = 8;

  // IDLE is all-zeros so a freshly reset state register reads as idle.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage : l_stages_pkg

// File: rtl/bf_launch_slot.sv
// -----------------------------------------------------------------------------
// bf_launch_slot
//
// Per-unit launch bookkeeping for one butterfly unit. Holds the "launched"
// and "finished" flags for the current stage, decodes the unit's start
// request from registered state only, and reports same-cycle accept and
// done-capture events so the controller can close a phase without waiting
// an extra cycle for the flags to update.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_clear         clear both flags (new run or next stage)
//   i_launch_phase  controller is in LAUNCH (registered decode)
//   i_capture_en    controller is in LAUNCH or WAIT
//   i_bf_ready      unit ready (accepts a start this cycle)
//   i_bf_done       unit done pulse
//   o_bf_start      start request to the unit
//   o_accept_now    start accepted this cycle
//   o_captured_now  done counted this cycle
//   o_launched      launched flag (registered)
//   o_finished      finished flag (registered)
// -----------------------------------------------------------------------------
module bf_launch_slot (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_launch_phase,
  input  logic i_capture_en,
  input  logic i_bf_ready,
  input  logic i_bf_done,
  output logic o_bf_start,
  output logic o_accept_now,
  output logic o_captured_now,
  output logic o_launched,
  output logic o_finished
);

  logic r_launched;
  logic r_finished;

  // Start comes only from registers, so it is glitch-free and independent
  // of the unit's own ready/done inputs.
  assign o_bf_start     = i_launch_phase & ~r_launched;
  assign o_accept_now   = o_bf_start & i_bf_ready;

  // A done only counts for a unit that is launched, or is being launched in
  // this very cycle; anything else is a stray pulse and is dropped.
  assign o_captured_now = i_capture_en & i_bf_done & (r_launched | o_accept_now);

  assign o_launched     = r_launched;
  assign o_finished     = r_finished;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_launched <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      if (o_accept_now)   r_launched <= 1'b1;
      if (o_captured_now) r_finished <= 1'b1;
    end
  end

endmodule : bf_launch_slot

// File: rtl/l_stages_ctrl.sv
// -----------------------------------------------------------------------------
// l_stages_ctrl
//
// Launch controller for the L-stage butterfly array. Accepts one ap_ctrl
// start carrying a base stage index and a stage count, then runs that many
// consecutive stages. In each stage every butterfly unit is started with a
// real start/ready handshake and its done pulse is collected; the next stage
// begins only once all units have finished. A single ap_done pulse marks the
// end of the last stage. A stage count of zero completes immediately.
//
// Parameters:
//   NUM_UNITS  number of butterfly units (>= 1)
//   STAGE_W    stage index width
//   CNT_W      stage count width
//
// Ports:
//   ap_clk       clock, rising edge
//   ap_rst       synchronous active-high reset
//   ap_start     run request, sampled only while idle
//   ap_ready     same as ap_done
//   ap_done      one-cycle completion pulse
//   ap_idle      high while idle
//   stage_base   first stage index, latched at start
//   stage_count  number of stages, latched at start
//   bf_stage     per-unit stage index (all slices carry the current stage)
//   bf_start     per-unit start request
//   bf_ready     per-unit ready (accepts start)
//   bf_done      per-unit done pulse
// -----------------------------------------------------------------------------
module l_stages_ctrl
  import l_stages_pkg::*;
#(
  parameter int NUM_UNITS = DEF_NUM_UNITS,
  parameter int STAGE_W   = DEF_STAGE_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_done,
  output logic                         ap_idle,
  input  logic [STAGE_W-1:0]           stage_base,
  input  logic [CNT_W-1:0]             stage_count,
  output logic [NUM_UNITS*STAGE_W-1:0] bf_stage,
  output logic [NUM_UNITS-1:0]         bf_start,
  input  logic [NUM_UNITS-1:0]         bf_ready,
  input  logic [NUM_UNITS-1:0]         bf_done
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STAGE_W-1:0] r_cur_stage;
  logic [CNT_W-1:0]   r_remaining;

  logic w_load;     // latch base/count at an accepted start
  logic w_advance;  // step to the next stage
  logic w_clear;    // clear all per-unit flags

  logic w_launch_phase;
  logic w_capture_en;

  logic [NUM_UNITS-1:0] w_accept_now;
  logic [NUM_UNITS-1:0] w_captured_now;
  logic [NUM_UNITS-1:0] w_launched;
  logic [NUM_UNITS-1:0] w_finished;

  logic w_all_launched;
  logic w_all_finished;

  assign w_launch_phase = (r_state == ST_LAUNCH);
  assign w_capture_en   = (r_state == ST_LAUNCH) || (r_state == ST_WAIT);

  // Include this cycle's events so a phase closes the same cycle its last
  // accept or done arrives.
  assign w_all_launched = &(w_launched | w_accept_now);
  assign w_all_finished = &(w_finished | w_captured_now);

  // ---------------------------------------------------------------------------
  // Per-unit launch slots and stage fan-out
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
    bf_launch_slot u_slot (
      .i_clk          (ap_clk),
      .i_rst          (ap_rst),
      .i_clear        (w_clear),
      .i_launch_phase (w_launch_phase),
      .i_capture_en   (w_capture_en),
      .i_bf_ready     (bf_ready[gi]),
      .i_bf_done      (bf_done[gi]),
      .o_bf_start     (bf_start[gi]),
      .o_accept_now   (w_accept_now[gi]),
      .o_captured_now (w_captured_now[gi]),
      .o_launched     (w_launched[gi]),
      .o_finished     (w_finished[gi])
    );

    assign bf_stage[gi*STAGE_W +: STAGE_W] = r_cur_stage;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (ap_start) begin
          w_load      = 1'b1;
          w_clear     = 1'b1;
          w_state_nxt = (stage_count == '0) ? ST_DONE : ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (w_all_launched) w_state_nxt = ST_WAIT;
      end

      ST_WAIT: begin
        if (w_all_finished) begin
          // remaining is at least 1 here; it is never stepped below 1.
          if (r_remaining > CNT_W'(1)) begin
            w_advance   = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = ST_LAUNCH;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, stage index and remaining-count registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state     <= ST_IDLE;
      r_cur_stage <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_cur_stage <= stage_base;
        r_remaining <= stage_count;
      end else if (w_advance) begin
        // Stage index wraps silently modulo 2^STAGE_W.
        r_cur_stage <= r_cur_stage + STAGE_W'(1);
        r_remaining <= r_remaining - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // ap_ctrl outputs, decoded from the state register
  // ---------------------------------------------------------------------------
  assign ap_done  = (r_state == ST_DONE);
  assign ap_ready = ap_done;
  assign ap_idle  = (r_state == ST_IDLE);

endmodule : l_stages_ctrl

// File: tb/tb_l_stages_ctrl.sv
// -----------------------------------------------------------------------------
// tb_l_stages_ctrl
//
// Self-checking bench for l_stages_ctrl (4 units, 32-bit stage, 8-bit count).
// Butterfly units are emulated in the bench: they raise ready, and after an
// accepted start they pulse done a chosen number of cycles later. A job-level
// model tracks, per stage, which units have been accepted and which have
// finished, and derives the expected stage index and the completion point.
// -----------------------------------------------------------------------------
module tb_l_stages_ctrl;

  localparam int NU = 4;
  localparam int SW = 32;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_idle;
  logic [SW-1:0]     stage_base;
  logic [CW-1:0]     stage_count;
  logic [NU*SW-1:0]  bf_stage;
  logic [NU-1:0]     bf_start;
  logic [NU-1:0]     bf_ready;
  logic [NU-1:0]     bf_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  l_stages_ctrl #(
    .NUM_UNITS (NU),
    .STAGE_W   (SW),
    .CNT_W     (CW)
  ) dut (
    .ap_clk      (clk),
    .ap_rst      (rst),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .stage_base  (stage_base),
    .stage_count (stage_count),
    .bf_stage    (bf_stage),
    .bf_start    (bf_start),
    .bf_ready    (bf_ready),
    .bf_done     (bf_done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] stage_of(input int i);
    return bf_stage[i*SW +: SW];
  endfunction

  // ---------------------------------------------------------------------------
  // One job: present a start, emulate the units, check against the model.
  // Cycle 0 is the cycle ap_start is presented; cycle c is observed at the
  // negedge after rising edge c-1.
  // ---------------------------------------------------------------------------
  task automatic run_job(input logic [SW-1:0] base, input int cnt,
                         input int ready_pct, input int dly_lo, input int dly_hi,
                         input int spur_pct,
                         output int done_cyc, output int n_stages, output logic [SW-1:0] last_stage);
    logic [SW-1:0] exp_stage;
    logic [NU-1:0] acc, fin, rdy, dn;
    int            cd [NU];
    int            left, pulses, final_cyc, d;
    bit            prev_any;

    exp_stage = base; left = cnt; acc = '0; fin = '0;
    pulses = 0; done_cyc = -1; n_stages = 0; last_stage = '0; prev_any = 1'b0;
    final_cyc = (cnt == 0) ? 0 : -1;
    for (int i = 0; i < NU; i++) cd[i] = 0;

    @(negedge clk);
    check("idle_before_start", ap_idle, 1);
    ap_start = 1'b1; stage_base = base; stage_count = cnt[CW-1:0];
    bf_ready = '0; bf_done = '0;

    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      ap_start = 1'b0;
      if (c == 1) check("idle_drops_after_start", ap_idle, 0);
      if (done_cyc > 0 && c == done_cyc + 1) check("idle_after_done", ap_idle, 1);

      if (ap_done) begin
        pulses++;
        if (done_cyc < 0) done_cyc = c;
        check("done_only_after_last_stage", left, 0);
        check("ready_equals_done", ap_ready, 1);
      end

      if (|bf_start) begin
        check("start_only_while_stages_left", left > 0, 1);
        check("start_only_to_unaccepted", bf_start & acc, 0);
        for (int i = 0; i < NU; i++) check("bf_stage_value", stage_of(i), exp_stage);
        if (!prev_any) begin
          n_stages++;
          last_stage = stage_of(0);
        end
      end
      prev_any = |bf_start;

      // Emulated butterfly units.
      rdy = '0; dn = '0;
      for (int i = 0; i < NU; i++) begin
        if ($urandom_range(99, 0) < ready_pct) rdy[i] = 1'b1;
        if (bf_start[i] && rdy[i]) begin
          d = $urandom_range(dly_hi, dly_lo);
          if (d == 0) dn[i] = 1'b1;
          else        cd[i] = d;
        end else if (cd[i] > 0) begin
          cd[i]--;
          if (cd[i] == 0) dn[i] = 1'b1;
        end else if (!acc[i] && spur_pct > 0 && $urandom_range(99, 0) < spur_pct) begin
          dn[i] = 1'b1;
        end
      end
      bf_ready = rdy;
      bf_done  = dn;

      // Job model: a done counts once the unit is accepted (same cycle too);
      // a stage ends when every unit has finished.
      if (left > 0) begin
        acc = acc | (bf_start & rdy);
        fin = fin | (dn & acc);
        if (&fin) begin
          left--;
          exp_stage = exp_stage + 1;
          acc = '0; fin = '0;
          if (left == 0) final_cyc = c;
        end
      end

      if (left == 0 && c >= final_cyc + 4) break;
    end

    check("job_completed_in_budget", left, 0);
    check("exactly_one_done_pulse", pulses, 1);
    check("done_latency_after_last_finish",
          (done_cyc - final_cyc >= 1) && (done_cyc - final_cyc <= 2), 1);
    bf_ready = '0; bf_done = '0;
  endtask

  typedef struct {
    logic [SW-1:0] base;
    int            cnt;
    int            dly;
    int            exp_done;
    logic [SW-1:0] exp_last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int dc, ns;
    logic [SW-1:0] ls;
    logic [SW-1:0] rb;

    // All units always ready, done 'dly' cycles after accept.
    vecs[0] = '{32'd5,         1, 1, 3,  32'd5};
    vecs[1] = '{32'd5,         1, 0, 3,  32'd5};
    vecs[2] = '{32'd10,        2, 1, 5,  32'd11};
    vecs[3] = '{32'd0,         3, 2, 10, 32'd2};
    vecs[4] = '{32'hFFFF_FFFF, 3, 1, 7,  32'd1};
    vecs[5] = '{32'd7,         4, 0, 9,  32'd10};

    rst = 1'b1; ap_start = 1'b0; stage_base = '0; stage_count = '0;
    bf_ready = '0; bf_done = '0;
    repeat (3) @(negedge clk);
    check("rst_idle",     ap_idle,  1);
    check("rst_done",     ap_done,  0);
    check("rst_ready",    ap_ready, 0);
    check("rst_bf_start", bf_start, 0);
    check("rst_bf_stage", bf_stage, 0);
    rst = 1'b0;

    // ---------------- table-driven jobs ----------------
    for (int v = 0; v < 6; v++) begin
      run_job(vecs[v].base, vecs[v].cnt, 100, vecs[v].dly, vecs[v].dly, 0, dc, ns, ls);
      check("vec_done_cycle", dc, vecs[v].exp_done);
      check("vec_stage_count", ns, vecs[v].cnt);
      check("vec_last_stage", ls, vecs[v].exp_last);
    end

    // ---------------- stage_count = 0 ----------------
    run_job(32'd3, 0, 100, 0, 0, 0, dc, ns, ls);
    check("zero_count_no_launch", ns, 0);
    check("zero_count_done_early", (dc >= 1) && (dc <= 2), 1);

    // ---------------- staggered handshake on unit 2 ----------------
    @(negedge clk);
    ap_start = 1'b1; stage_base = 32'h20; stage_count = 8'd1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      ap_start = 1'b0;
      if (c == 1) begin
        check("stag_all_start", bf_start, 4'b1111);
        check("stag_stage", stage_of(2), 32'h20);
      end else if (c <= 6) begin
        check("stag_unit2_holds", bf_start, 4'b0100);
      end else begin
        check("stag_starts_low", bf_start, 4'b0000);
      end
      if (c < 8)       check("stag_no_early_done", ap_done, 0);
      else if (c == 8) check("stag_done", ap_done, 1);
      else             check("stag_idle", ap_idle, 1);
      bf_ready = (c >= 6) ? 4'b1111 : 4'b1011;
      // done[2] at cycle 3 precedes its accept and must be ignored.
      bf_done  = (c == 2) ? 4'b1011 : (c == 3 || c == 7) ? 4'b0100 : 4'b0000;
    end
    bf_ready = '0; bf_done = '0;

    // ------- early done on unit 1, ap_start held high during the run -------
    @(negedge clk);
    ap_start = 1'b1; stage_base = 32'd9; stage_count = 8'd1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 6)      check("spur_no_done", ap_done, 0);
      else if (c == 7) check("spur_done", ap_done, 1);
      else             check("spur_idle_after", ap_idle, 1);
      if (c >= 4 && c <= 6) begin
        check("hold_no_restart", bf_start, 0);
        check("hold_busy", ap_idle, 0);
      end
      ap_start = (c < 7);
      bf_ready = (c >= 3) ? 4'b1111 : 4'b1101;
      bf_done  = (c == 1) ? 4'b1101 : (c == 2 || c == 6) ? 4'b0010 : 4'b0000;
    end
    ap_start = 1'b0; bf_ready = '0; bf_done = '0;

    // ---------------- reset during WAIT ----------------
    @(negedge clk);
    ap_start = 1'b1; stage_base = 32'd4; stage_count = 8'd2;
    @(negedge clk);
    ap_start = 1'b0; bf_ready = 4'b1111;        // cycle 1: all accepted
    @(negedge clk);
    check("rst_mid_in_wait", bf_start, 0);      // cycle 2: WAIT
    bf_ready = '0;
    @(negedge clk);
    rst = 1'b1;                                 // cycle 3: reset sampled
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_idle",     ap_idle,  1);
    check("rst_mid_bf_start", bf_start, 0);
    check("rst_mid_done",     ap_done,  0);
    check("rst_mid_stage",    stage_of(0), 0);
    bf_done = 4'b1111;                          // stale dones after reset
    @(negedge clk);
    bf_done = '0;
    check("rst_stale_done_ignored", ap_done, 0);
    check("rst_stays_idle", ap_idle, 1);
    run_job(32'h40, 2, 100, 1, 1, 0, dc, ns, ls);
    check("rst_rerun_done_cycle", dc, 5);
    check("rst_rerun_last_stage", ls, 32'h41);

    // ---------------- randomized jobs ----------------
    for (int j = 0; j < 25; j++) begin
      rb = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
      run_job(rb, $urandom_range(4, 0), $urandom_range(100, 30), 0, 4, 15, dc, ns, ls);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_l_stages_ctrl
